// File: rtl/line_buffered_window_converter.sv
// ---------------------------------------------------------------------------
// line_buffered_window_converter
//
// Converts a DE-qualified RGB pixel stream to grayscale and keeps
// P_MATRIX_SIZE-1 lines in on-chip buffers. For every accepted pixel whose
// P_MATRIX_SIZE x P_MATRIX_SIZE neighbourhood lies fully inside the frame, it
// emits one grayscale window, optionally without the center pixel.
//
// Ports:
//   I_CLK                 clock, all state on the rising edge
//   I_RESET               asynchronous active-low reset
//   I_ENABLE              global enable, low = full stall
//   I_PIXEL               {R,G,B}, R in the MSBs
//   I_DATA_ENABLE         pixel valid
//   I_VSYNC               active-high frame start
//   O_PIXEL_COLUMN        window top-left column
//   O_PIXEL_ROW           window top-left row
//   O_PIXEL_MATRIX        row-major window, top-left pixel in the MSBs
//   O_PIXEL_MATRIX_READY  one-cycle strobe, outputs valid when high
//   O_OVERFLOW            sticky, a line or frame exceeded the parameters
// ---------------------------------------------------------------------------
module line_buffered_window_converter #(
    parameter int P_FRAME_COLUMNS  = 640,
    parameter int P_FRAME_ROWS     = 480,
    parameter int P_PIXEL_DEPTH    = 24,
    parameter int P_MATRIX_SIZE    = 3,
    parameter int P_EXCLUDE_CENTER = 1,
    parameter int P_GRAY_MODE      = 0,
    localparam int SUB = P_PIXEL_DEPTH / 3,
    localparam int CB  = $clog2(P_FRAME_COLUMNS),
    localparam int RB  = $clog2(P_FRAME_ROWS),
    localparam int MB  = SUB * (P_MATRIX_SIZE * P_MATRIX_SIZE - P_EXCLUDE_CENTER)
) (
    input  logic                     I_CLK,
    input  logic                     I_RESET,
    input  logic                     I_ENABLE,
    input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
    input  logic                     I_DATA_ENABLE,
    input  logic                     I_VSYNC,
    output logic [CB-1:0]            O_PIXEL_COLUMN,
    output logic [RB-1:0]            O_PIXEL_ROW,
    output logic [MB-1:0]            O_PIXEL_MATRIX,
    output logic                     O_PIXEL_MATRIX_READY,
    output logic                     O_OVERFLOW
);

    localparam int          N      = P_MATRIX_SIZE;
    localparam int unsigned NU     = P_MATRIX_SIZE;
    localparam int unsigned CENTER = (NU * NU) / 2;
    // Counters need one extra code to represent "one past the last pixel/line".
    localparam int          CW     = $clog2(P_FRAME_COLUMNS + 1);
    localparam int          RW     = $clog2(P_FRAME_ROWS + 1);

    // -----------------------------------------------------------------------
    // Input qualification and counters
    // -----------------------------------------------------------------------
    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic           r_de_prev;
    logic           r_overflow;

    logic           w_req;
    logic           w_in_bounds;
    logic           w_accept;
    logic           w_de_fall;

    assign w_req       = I_DATA_ENABLE && !I_VSYNC;
    assign w_in_bounds = (r_col < CW'(P_FRAME_COLUMNS)) && (r_row < RW'(P_FRAME_ROWS));
    assign w_accept    = w_req && w_in_bounds;
    assign w_de_fall   = r_de_prev && !I_DATA_ENABLE;

    // -----------------------------------------------------------------------
    // Grayscale conversion
    // -----------------------------------------------------------------------
    logic [SUB-1:0] w_r;
    logic [SUB-1:0] w_g;
    logic [SUB-1:0] w_b;
    logic [SUB+1:0] w_sum;
    logic [SUB-1:0] w_max;
    logic [SUB-1:0] w_gray;

    assign w_r = I_PIXEL[P_PIXEL_DEPTH-1 -: SUB];
    assign w_g = I_PIXEL[2*SUB-1 -: SUB];
    assign w_b = I_PIXEL[SUB-1:0];

    always_comb begin
        w_sum = {2'b00, w_r} + {1'b0, w_g, 1'b0} + {2'b00, w_b};
        w_max = (w_r > w_g) ? w_r : w_g;
        if (w_b > w_max) begin
            w_max = w_b;
        end
        case (P_GRAY_MODE)
            1:       w_gray = w_g;
            2:       w_gray = w_max;
            default: w_gray = w_sum[SUB+1:2];
        endcase
    end

    // -----------------------------------------------------------------------
    // Stage 1: counters, grayscale register and position/valid tag
    // -----------------------------------------------------------------------
    logic           r_s1_valid;
    logic [SUB-1:0] r_s1_gray;
    logic [CW-1:0]  r_s1_col;
    logic [RW-1:0]  r_s1_row;

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            r_col      <= '0;
            r_row      <= '0;
            r_de_prev  <= 1'b0;
            r_overflow <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_gray  <= '0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
        end else if (I_ENABLE) begin
            r_de_prev  <= I_DATA_ENABLE;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_gray <= w_gray;
                r_s1_col  <= r_col;
                r_s1_row  <= r_row;
            end
            // VSYNC wins over a simultaneous DE fall.
            if (I_VSYNC) begin
                r_col      <= '0;
                r_row      <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_req && !w_in_bounds) begin
                    r_overflow <= 1'b1;
                end
                if (w_de_fall) begin
                    r_col <= '0;
                    if (r_row < RW'(P_FRAME_ROWS)) begin
                        r_row <= r_row + RW'(1);
                    end
                end else if (w_accept) begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: line buffers and sliding window
    // -----------------------------------------------------------------------
    // r_line[k] holds row r-1-k; r_win is indexed [row][column], row 0 on top.
    logic [SUB-1:0] r_line [N-1][P_FRAME_COLUMNS];
    logic [SUB-1:0] r_win      [N][N];
    logic [SUB-1:0] w_win_next [N][N];
    logic [SUB-1:0] w_new_col  [N];
    logic [CB-1:0]  w_addr;
    logic [MB-1:0]  w_flat;
    logic           w_win_full;
    logic [CW-1:0]  w_col_off;
    logic [RW-1:0]  w_row_off;

    logic           r_ready;
    logic [CB-1:0]  r_out_col;
    logic [RB-1:0]  r_out_row;
    logic [MB-1:0]  r_matrix;

    assign w_addr     = r_s1_col[CB-1:0];
    assign w_win_full = r_s1_valid && (r_s1_col >= CW'(N-1)) && (r_s1_row >= RW'(N-1));
    assign w_col_off  = r_s1_col - CW'(N-1);
    assign w_row_off  = r_s1_row - RW'(N-1);

    // Position of window element (r,c) in the flattened output, counted from
    // the MSB end, closing the gap left by an excluded center.
    function automatic int unsigned slot(input int unsigned r, input int unsigned c);
        int unsigned idx;
        idx = r * NU + c;
        if (P_EXCLUDE_CENTER != 0 && idx > CENTER) begin
            idx = idx - 1;
        end
        return idx;
    endfunction

    always_comb begin
        for (int unsigned r = 0; r < NU - 1; r++) begin
            w_new_col[r] = r_line[NU-2-r][w_addr];
        end
        w_new_col[N-1] = r_s1_gray;
    end

    always_comb begin
        for (int unsigned r = 0; r < NU; r++) begin
            for (int unsigned c = 0; c < NU - 1; c++) begin
                w_win_next[r][c] = r_win[r][c+1];
            end
            w_win_next[r][N-1] = w_new_col[r];
        end
    end

    always_comb begin
        w_flat = '0;
        for (int unsigned r = 0; r < NU; r++) begin
            for (int unsigned c = 0; c < NU; c++) begin
                if (!(P_EXCLUDE_CENTER != 0 && r == NU / 2 && c == NU / 2)) begin
                    w_flat[MB - 1 - SUB * slot(r, c) -: SUB] = w_win_next[r][c];
                end
            end
        end
    end

    // Line-buffer contents need no reset; every column is rewritten before
    // it can contribute to a window that raises ready.
    always_ff @(posedge I_CLK) begin
        if (I_ENABLE && r_s1_valid) begin
            r_line[0][w_addr] <= r_s1_gray;
            for (int unsigned k = 1; k < NU - 1; k++) begin
                r_line[k][w_addr] <= r_line[k-1][w_addr];
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            r_ready   <= 1'b0;
            r_out_col <= '0;
            r_out_row <= '0;
            r_matrix  <= '0;
            for (int unsigned r = 0; r < NU; r++) begin
                for (int unsigned c = 0; c < NU; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (!I_ENABLE) begin
            // Clearing (not holding) ready keeps a strobe from repeating
            // across a stall; the pending stage-1 pixel is processed later.
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_win_full && !I_VSYNC;
            if (r_s1_valid) begin
                r_win <= w_win_next;
            end
            if (w_win_full && !I_VSYNC) begin
                r_out_col <= w_col_off[CB-1:0];
                r_out_row <= w_row_off[RB-1:0];
                r_matrix  <= w_flat;
            end
        end
    end

    assign O_PIXEL_COLUMN       = r_out_col;
    assign O_PIXEL_ROW          = r_out_row;
    assign O_PIXEL_MATRIX       = r_matrix;
    assign O_PIXEL_MATRIX_READY = r_ready;
    assign O_OVERFLOW           = r_overflow;

endmodule

// File: tb/tb_line_buffered_window_converter.sv
// ---------------------------------------------------------------------------
// tb_line_buffered_window_converter
//
// Directed bench for line_buffered_window_converter on an 8x6 frame. Four
// instances share one stimulus stream: N=3 in gray modes 0/1/2 with the center
// excluded, and N=5 with the center included.
// ---------------------------------------------------------------------------
module tb_line_buffered_window_converter;

    localparam int COLS = 8;
    localparam int ROWS = 6;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b1;
    logic        de    = 1'b0;
    logic        vs    = 1'b0;
    logic [23:0] pix   = '0;

    always #5 clk = ~clk;

    logic [2:0]   col0, col1, col2, col5;
    logic [2:0]   row0, row1, row2, row5;
    logic [63:0]  mat0, mat1, mat2;
    logic [199:0] mat5;
    logic         rdy0, rdy1, rdy2, rdy5;
    logic         ovf0, ovf1, ovf2, ovf5;

    line_buffered_window_converter #(
        .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS), .P_PIXEL_DEPTH(24),
        .P_MATRIX_SIZE(3), .P_EXCLUDE_CENTER(1), .P_GRAY_MODE(0)
    ) u_dut0 (
        .I_CLK(clk), .I_RESET(rst_n), .I_ENABLE(en), .I_PIXEL(pix),
        .I_DATA_ENABLE(de), .I_VSYNC(vs), .O_PIXEL_COLUMN(col0),
        .O_PIXEL_ROW(row0), .O_PIXEL_MATRIX(mat0),
        .O_PIXEL_MATRIX_READY(rdy0), .O_OVERFLOW(ovf0)
    );

    line_buffered_window_converter #(
        .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS), .P_PIXEL_DEPTH(24),
        .P_MATRIX_SIZE(3), .P_EXCLUDE_CENTER(1), .P_GRAY_MODE(1)
    ) u_dut1 (
        .I_CLK(clk), .I_RESET(rst_n), .I_ENABLE(en), .I_PIXEL(pix),
        .I_DATA_ENABLE(de), .I_VSYNC(vs), .O_PIXEL_COLUMN(col1),
        .O_PIXEL_ROW(row1), .O_PIXEL_MATRIX(mat1),
        .O_PIXEL_MATRIX_READY(rdy1), .O_OVERFLOW(ovf1)
    );

    line_buffered_window_converter #(
        .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS), .P_PIXEL_DEPTH(24),
        .P_MATRIX_SIZE(3), .P_EXCLUDE_CENTER(1), .P_GRAY_MODE(2)
    ) u_dut2 (
        .I_CLK(clk), .I_RESET(rst_n), .I_ENABLE(en), .I_PIXEL(pix),
        .I_DATA_ENABLE(de), .I_VSYNC(vs), .O_PIXEL_COLUMN(col2),
        .O_PIXEL_ROW(row2), .O_PIXEL_MATRIX(mat2),
        .O_PIXEL_MATRIX_READY(rdy2), .O_OVERFLOW(ovf2)
    );

    line_buffered_window_converter #(
        .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS), .P_PIXEL_DEPTH(24),
        .P_MATRIX_SIZE(5), .P_EXCLUDE_CENTER(0), .P_GRAY_MODE(0)
    ) u_dut5 (
        .I_CLK(clk), .I_RESET(rst_n), .I_ENABLE(en), .I_PIXEL(pix),
        .I_DATA_ENABLE(de), .I_VSYNC(vs), .O_PIXEL_COLUMN(col5),
        .O_PIXEL_ROW(row5), .O_PIXEL_MATRIX(mat5),
        .O_PIXEL_MATRIX_READY(rdy5), .O_OVERFLOW(ovf5)
    );

    // Cycle counter and strobe logs, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]   q_col[$];
    logic [2:0]   q_row[$];
    logic [63:0]  q_mat[$];
    int           q_cyc[$];
    logic [2:0]   q5_col[$];
    logic [2:0]   q5_row[$];
    logic [199:0] q5_mat[$];

    always @(negedge clk) begin
        if (rdy0) begin
            q_col.push_back(col0);
            q_row.push_back(row0);
            q_mat.push_back(mat0);
            q_cyc.push_back(cyc);
        end
        if (rdy5) begin
            q5_col.push_back(col5);
            q5_row.push_back(row5);
            q5_mat.push_back(mat5);
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int pix22_cyc = 0;
    int stall_strobes = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ramp(input int r, input int c);
        logic [7:0] g;
        g = 8'(16 * r + c);
        return {g, g, g};
    endfunction

    // Expected N=3 center-excluded window with top-left at (r0,c0) of the ramp.
    function automatic logic [63:0] exp_mat3(input int r0, input int c0);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!(i == 1 && j == 1)) begin
                    m = {m[55:0], 8'(16 * (r0 + i) + c0 + j)};
                end
            end
        end
        return m;
    endfunction

    task automatic vsync_pulse;
        de = 1'b0;
        vs = 1'b1;
        tick();
        tick();
        vs = 1'b0;
        tick();
    endtask

    task automatic drive_line(input int r, input int n, input bit use_k,
                              input logic [23:0] k, input int stall_c);
        for (int c = 0; c < n; c++) begin
            pix = use_k ? k : ramp(r, c);
            de  = 1'b1;
            if (c == stall_c) begin
                en = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    if (rdy0) stall_strobes++;
                end
                en = 1'b1;
            end
            if (!use_k && r == 2 && c == 2) pix22_cyc = cyc;
            tick();
        end
        de = 1'b0;
        tick();
        tick();
    endtask

    task automatic drive_rows(input int from, input int to, input bit use_k,
                              input logic [23:0] k, input int stall_r, input int stall_c);
        for (int r = from; r <= to; r++) begin
            drive_line(r, COLS, use_k, k, (r == stall_r) ? stall_c : -1);
        end
    endtask

    // All 24 strobes of a ramp frame, in raster order, against the model.
    task automatic check_frame(input int s, input string tag);
        check({tag, "_cnt"}, 256'(q_mat.size() - s), 256'(24));
        for (int j = 0; j < 24; j++) begin
            if (s + j < q_mat.size()) begin
                check($sformatf("%s_w%0d", tag, j),
                      {q_col[s+j], q_row[s+j], q_mat[s+j]},
                      {3'(j % 6), 3'(j / 6), exp_mat3(j / 6, j % 6)});
            end
        end
    endtask

    logic [23:0] g_pix [4] = '{24'h402010, 24'hFFFFFF, 24'h10A030, 24'h123456};
    logic [7:0]  g_exp [4][3] = '{'{8'h24, 8'h20, 8'h40},
                                  '{8'hFF, 8'hFF, 8'hFF},
                                  '{8'h60, 8'hA0, 8'hA0},
                                  '{8'h34, 8'h34, 8'h56}};

    initial begin
        int s;
        int s5;
        logic [7:0] g;

        // Reset state
        tick();
        tick();
        tick();
        check("rst_rdy", rdy0, 1'b0);
        check("rst_col", col0, 3'd0);
        check("rst_row", row0, 3'd0);
        check("rst_mat", mat0, 64'd0);
        check("rst_ovf", ovf0, 1'b0);
        check("rst_mat5", mat5, 200'd0);
        rst_n = 1'b1;
        tick();

        // Grayscale math: constant frames, every window byte is the gray value
        for (int i = 0; i < 4; i++) begin
            vsync_pulse();
            drive_rows(0, ROWS - 1, 1'b1, g_pix[i], -1, -1);
            g = g_exp[i][0];
            check($sformatf("gray%0d_m0", i), mat0, {8{g}});
            g = g_exp[i][1];
            check($sformatf("gray%0d_m1", i), mat1, {8{g}});
            g = g_exp[i][2];
            check($sformatf("gray%0d_m2", i), mat2, {8{g}});
        end

        // Ramp frame, unstalled
        s  = q_mat.size();
        s5 = q5_mat.size();
        vsync_pulse();
        drive_rows(0, ROWS - 1, 1'b0, '0, -1, -1);
        check("first_present", 256'(q_mat.size() > s), 256'(1));
        if (q_mat.size() > s) begin
            check("first_latency", 256'(q_cyc[s] - pix22_cyc), 256'(2));
            check("first_win", {q_col[s], q_row[s], q_mat[s]},
                  {3'd0, 3'd0, 64'h00_01_02_10_12_20_21_22});
        end
        check_frame(s, "ramp");
        check("n5_cnt", 256'(q5_mat.size() - s5), 256'(8));
        if (q5_mat.size() > s5) begin
            check("n5_pos", {q5_col[s5], q5_row[s5]}, 6'd0);
            check("n5_center", q5_mat[s5][103:96], 8'h22);
            check("n5_tl", q5_mat[s5][199:192], 8'h00);
            check("n5_br", q5_mat[s5][7:0], 8'h44);
        end

        // Stall mid-line with DE held high
        s = q_mat.size();
        stall_strobes = 0;
        vsync_pulse();
        drive_rows(0, ROWS - 1, 1'b0, '0, 3, 4);
        check("stall_quiet", 256'(stall_strobes), 256'(0));
        check_frame(s, "stall");

        // Overflow: 10 pixels on line 0, extra two dropped
        s = q_mat.size();
        vsync_pulse();
        check("ovf_pre", ovf0, 1'b0);
        drive_line(0, COLS + 2, 1'b0, '0, -1);
        check("ovf_set", ovf0, 1'b1);
        drive_rows(1, ROWS - 1, 1'b0, '0, -1, -1);
        check_frame(s, "ovf");
        check("ovf_sticky", ovf0, 1'b1);

        // Mid-stream asynchronous reset
        de  = 1'b1;
        pix = ramp(0, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_rdy", rdy0, 1'b0);
        check("mrst_col", col0, 3'd0);
        check("mrst_row", row0, 3'd0);
        check("mrst_mat", mat0, 64'd0);
        check("mrst_ovf", ovf0, 1'b0);
        de = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        s = q_mat.size();
        drive_rows(0, 1, 1'b0, '0, -1, -1);
        check("mrst_quiet", 256'(q_mat.size() - s), 256'(0));

        // VSYNC mid-frame clears overflow and restarts counting
        vsync_pulse();
        drive_line(0, COLS + 2, 1'b0, '0, -1);
        drive_rows(1, 2, 1'b0, '0, -1, -1);
        check("mvs_ovf_set", ovf0, 1'b1);
        vsync_pulse();
        check("mvs_ovf_clr", ovf0, 1'b0);
        s = q_mat.size();
        drive_rows(0, 1, 1'b0, '0, -1, -1);
        check("mvs_quiet", 256'(q_mat.size() - s), 256'(0));
        drive_rows(2, ROWS - 1, 1'b0, '0, -1, -1);
        check_frame(s, "mvs");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
